// File: rtl/fnd_pkg.sv
// ---------------------------------------------------------------------------
// fnd_pkg
//   Shared definitions for the FND scan decoder:
//   - active-low 7-segment patterns (bit0 = a ... bit6 = g)
//   - decoded class of a segment pattern (value / blank / error)
//   - scan FSM state encoding
//   - the per-digit record (class + hex value) used by the stability filter
// ---------------------------------------------------------------------------
package fnd_pkg;

  // Active-low segment patterns, written g..a (MSB first).
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_7_ALT = 7'b1011000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_B_ALT = 7'b0000111;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // What a captured segment pattern turned out to be.
  typedef enum logic [1:0] {
    CLS_VAL   = 2'd0,
    CLS_BLANK = 2'd1,
    CLS_ERR   = 2'd2
  } cls_e;

  // Scan FSM states. The ST_ prefix keeps the settle state from colliding
  // with the SETTLE parameter of the top module.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  // One decoded digit. For blank/error the hex field is always zero, so two
  // records compare equal exactly when they describe the same display state.
  typedef struct packed {
    cls_e       cls;
    logic [3:0] hex;
  } digit_t;

endpackage : fnd_pkg

// File: rtl/fnd_seg2hex.sv
// ---------------------------------------------------------------------------
// fnd_seg2hex
//   Combinational inverse of a hex-to-7-segment encoder.
//   Ports:
//     i_seg [6:0]  active-low segment pattern, bit0 = a ... bit6 = g
//     o_hex [3:0]  recovered hex value (0 for blank or undecodable patterns)
//     o_cls        CLS_VAL, CLS_BLANK or CLS_ERR
// ---------------------------------------------------------------------------
module fnd_seg2hex
  import fnd_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_hex,
  output cls_e       o_cls
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    o_hex = 4'h0;
    o_cls = CLS_VAL;
    case (i_seg)
      SEG_0:             o_hex = 4'h0;
      SEG_1:             o_hex = 4'h1;
      SEG_2:             o_hex = 4'h2;
      SEG_3:             o_hex = 4'h3;
      SEG_4:             o_hex = 4'h4;
      SEG_5:             o_hex = 4'h5;
      SEG_6:             o_hex = 4'h6;
      SEG_7, SEG_7_ALT:  o_hex = 4'h7;
      SEG_8:             o_hex = 4'h8;
      SEG_9:             o_hex = 4'h9;
      SEG_A:             o_hex = 4'hA;
      SEG_B, SEG_B_ALT:  o_hex = 4'hB;
      SEG_C:             o_hex = 4'hC;
      SEG_D:             o_hex = 4'hD;
      SEG_E:             o_hex = 4'hE;
      SEG_F:             o_hex = 4'hF;
      SEG_BLANK:         o_cls = CLS_BLANK;
      default:           o_cls = CLS_ERR;
    endcase
  end

endmodule : fnd_seg2hex

// File: rtl/fnd_scan_decoder.sv
// ---------------------------------------------------------------------------
// fnd_scan_decoder
//   Snoops a multiplexed, active-low 7-segment display bus and recovers the
//   hex digit shown on each position. A slot is captured once the
//   synchronized bus has been stable for SETTLE samples; a digit is
//   committed once STABLE_SCANS consecutive captures of it agree.
//   Parameters:
//     N_DIG         number of digit positions (1..8)
//     SETTLE        identical samples needed before a slot is captured
//     STABLE_SCANS  identical captures needed before a digit is committed
//   Ports:
//     i_clk, i_rst        clock, asynchronous active-high reset
//     i_com [N_DIG-1:0]   digit commons, active-low one-hot
//     i_seg [6:0]         segment lines, active-low, bit0 = a ... bit6 = g
//     o_hex [4*N_DIG-1:0] committed value, digit k in [4k+3:4k]
//     o_valid/o_blank/o_err [N_DIG-1:0]  committed class per digit
//     o_upd               one-cycle pulse when any committed state changes
// ---------------------------------------------------------------------------
module fnd_scan_decoder #(
  parameter int unsigned N_DIG        = 4,
  parameter int unsigned SETTLE       = 8,
  parameter int unsigned STABLE_SCANS = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_DIG-1:0]     i_com,
  input  logic [6:0]           i_seg,
  output logic [4*N_DIG-1:0]   o_hex,
  output logic [N_DIG-1:0]     o_valid,
  output logic [N_DIG-1:0]     o_blank,
  output logic [N_DIG-1:0]     o_err,
  output logic                 o_upd
);

  import fnd_pkg::*;

  localparam int unsigned IDX_W   = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [7:0]  CNT_TGT = 8'(SETTLE);
  localparam logic [3:0]  MATCH_TGT = 4'(STABLE_SCANS);

  // -------------------------------------------------------------------------
  // Input synchronizer. Commons and segments travel through the same two
  // stages, so a digit switch appears atomically on the synchronized side.
  // The idle value is all-ones (nothing lit).
  // -------------------------------------------------------------------------
  logic [N_DIG-1:0] com_meta, s_com;
  logic [6:0]       seg_meta, s_seg;

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values and the two synchronizer stages really are
  // two cycles apart.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      com_meta <= '1;
      s_com    <= '1;
      seg_meta <= '1;
      s_seg    <= '1;
    end else begin
      com_meta <= i_com;
      s_com    <= com_meta;
      seg_meta <= i_seg;
      s_seg    <= seg_meta;
    end
  end

  // -------------------------------------------------------------------------
  // One-hot-low check and lit-digit index.
  // -------------------------------------------------------------------------
  logic             com_ok;
  logic [IDX_W-1:0] com_idx;

  assign com_ok = $onehot(~s_com);

  always_comb begin
    com_idx = '0;
    for (int k = 0; k < N_DIG; k++) begin
      if (!s_com[k]) com_idx = IDX_W'(k);
    end
  end

  // -------------------------------------------------------------------------
  // Scan FSM: track one slot, count identical samples, capture once.
  // -------------------------------------------------------------------------
  state_e           state, state_n;
  logic [7:0]       cnt, cnt_n;
  logic [N_DIG-1:0] ref_com, ref_com_n;
  logic [6:0]       ref_seg, ref_seg_n;
  logic [IDX_W-1:0] ref_idx, ref_idx_n;
  logic             cap;
  logic             relatch;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ref_com <= '1;
      ref_seg <= '1;
      ref_idx <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      ref_com <= ref_com_n;
      ref_seg <= ref_seg_n;
      ref_idx <= ref_idx_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ref_com_n = ref_com;
    ref_seg_n = ref_seg;
    ref_idx_n = ref_idx;
    cap       = 1'b0;
    relatch   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (com_ok) relatch = 1'b1;
      end

      ST_SETTLE: begin
        if (s_com == ref_com && s_seg == ref_seg) begin
          cnt_n = cnt + 8'd1;
          if (cnt_n == CNT_TGT) begin
            cap     = 1'b1;
            state_n = ST_HOLD;
          end
        end else if (com_ok) begin
          relatch = 1'b1;
        end else begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      end

      ST_HOLD: begin
        // Segment changes within a held slot are ignored; only a change of
        // the lit digit ends the slot.
        if (s_com != ref_com) begin
          if (com_ok) begin
            relatch = 1'b1;
          end else begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase

    // Start a new slot on the current sample; it counts as the first one.
    if (relatch) begin
      state_n   = ST_SETTLE;
      cnt_n     = 8'd1;
      ref_com_n = s_com;
      ref_seg_n = s_seg;
      ref_idx_n = com_idx;
    end
  end

  // -------------------------------------------------------------------------
  // Decode of the captured slot.
  // -------------------------------------------------------------------------
  logic [3:0] dec_hex;
  cls_e       dec_cls;
  digit_t     dec;

  fnd_seg2hex u_seg2hex (
    .i_seg (ref_seg),
    .o_hex (dec_hex),
    .o_cls (dec_cls)
  );

  assign dec = '{cls: dec_cls, hex: dec_hex};

  // -------------------------------------------------------------------------
  // Per-digit stability filter and committed state.
  // -------------------------------------------------------------------------
  digit_t           cand  [N_DIG];
  logic [3:0]       match [N_DIG];
  digit_t           comm  [N_DIG];
  logic [N_DIG-1:0] comm_set;
  logic [3:0]       match_n;
  logic             commit;
  logic             upd;

  always_comb begin
    if (dec == cand[ref_idx]) begin
      match_n = (match[ref_idx] >= MATCH_TGT) ? MATCH_TGT : match[ref_idx] + 4'd1;
    end else begin
      match_n = 4'd1;
    end
    // On reaching the target the candidate is (or becomes) dec, so compare
    // the committed state against dec directly.
    commit = cap && (match_n == MATCH_TGT) &&
             (!comm_set[ref_idx] || comm[ref_idx] != dec);
  end

  // NOTE: the per-digit arrays are small register files, not RAM, and their
  // cleared state is part of the filter's behaviour, so they are reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < N_DIG; k++) begin
        cand[k]  <= '0;
        match[k] <= '0;
        comm[k]  <= '0;
      end
      comm_set <= '0;
      upd      <= 1'b0;
    end else begin
      if (cap) begin
        cand[ref_idx]  <= dec;
        match[ref_idx] <= match_n;
        if (commit) begin
          comm[ref_idx]     <= dec;
          comm_set[ref_idx] <= 1'b1;
        end
      end
      upd <= commit;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: flags are mutually exclusive once a digit has been committed.
  // -------------------------------------------------------------------------
  always_comb begin
    o_hex   = '0;
    o_valid = '0;
    o_blank = '0;
    o_err   = '0;
    for (int k = 0; k < N_DIG; k++) begin
      o_valid[k] = comm_set[k] && (comm[k].cls == CLS_VAL);
      o_blank[k] = comm_set[k] && (comm[k].cls == CLS_BLANK);
      o_err[k]   = comm_set[k] && (comm[k].cls == CLS_ERR);
      o_hex[4*k +: 4] = o_valid[k] ? comm[k].hex : 4'h0;
    end
  end

  assign o_upd = upd;

endmodule : fnd_scan_decoder

// File: tb/tb_fnd_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_fnd_scan_decoder
//   Directed bench for fnd_scan_decoder with default parameters
//   (N_DIG=4, SETTLE=8, STABLE_SCANS=2). Inputs change on falling edges,
//   outputs are checked 1 ns after a falling edge.
// ---------------------------------------------------------------------------
module tb_fnd_scan_decoder;

  // Hand-written segment patterns (active-low, g..a).
  localparam logic [6:0] P_1     = 7'b1111001;
  localparam logic [6:0] P_2     = 7'b0100100;
  localparam logic [6:0] P_3     = 7'b0110000;
  localparam logic [6:0] P_5     = 7'b0010010;
  localparam logic [6:0] P_6     = 7'b0000010;
  localparam logic [6:0] P_8     = 7'b0000000;
  localparam logic [6:0] P_A     = 7'b0001000;
  localparam logic [6:0] P_7ALT  = 7'b1011000;
  localparam logic [6:0] P_BALT  = 7'b0000111;
  localparam logic [6:0] P_BAD   = 7'b1110111;
  localparam logic [6:0] P_BLANK = 7'b1111111;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [3:0]  i_com;
  logic [6:0]  i_seg;
  logic [15:0] o_hex;
  logic [3:0]  o_valid;
  logic [3:0]  o_blank;
  logic [3:0]  o_err;
  logic        o_upd;

  int n_assert = 0;
  int n_fail   = 0;
  int upd_cnt  = 0;
  int upd_base = 0;

  fnd_scan_decoder dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_com   (i_com),
    .i_seg   (i_seg),
    .o_hex   (o_hex),
    .o_valid (o_valid),
    .o_blank (o_blank),
    .o_err   (o_err),
    .o_upd   (o_upd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_upd) upd_cnt = upd_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [15:0] hex, input logic [3:0] val,
                           input logic [3:0] blk, input logic [3:0] err);
    check({tag, ".hex"},   32'(o_hex),   32'(hex));
    check({tag, ".valid"}, 32'(o_valid), 32'(val));
    check({tag, ".blank"}, 32'(o_blank), 32'(blk));
    check({tag, ".err"},   32'(o_err),   32'(err));
  endtask

  task automatic check_upd(input string tag, input int exp);
    check({tag, ".upd_pulses"}, 32'(upd_cnt - upd_base), 32'(exp));
    upd_base = upd_cnt;
  endtask

  // Hold one bus state for n clock cycles.
  task automatic drive(input logic [3:0] com, input logic [6:0] seg, input int n);
    i_com = com;
    i_seg = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive(4'b1111, P_BLANK, n);
    #1;
  endtask

  // One full scan of all four digits, 20 cycles per slot; segs = {d3,d2,d1,d0}.
  task automatic scan4(input logic [27:0] segs);
    for (int d = 0; d < 4; d++) begin
      drive(~(4'b0001 << d), segs[7*d +: 7], 20);
    end
  endtask

  initial begin
    i_rst = 1'b1;
    i_com = 4'b1111;
    i_seg = P_BLANK;
    repeat (3) @(negedge clk);
    #1;
    check_out("reset", 16'h0000, 4'b0000, 4'b0000, 4'b0000);
    check("reset.upd", 32'(o_upd), 32'h0);
    @(negedge clk);
    i_rst = 1'b0;
    idle(4);

    // Basic scan of 1,2,3,A.
    scan4({P_A, P_3, P_2, P_1});
    idle(4);
    check_out("basic.scan1", 16'h0000, 4'b0000, 4'b0000, 4'b0000);
    check_upd("basic.scan1", 0);
    scan4({P_A, P_3, P_2, P_1});
    idle(4);
    check_out("basic.scan2", 16'hA321, 4'b1111, 4'b0000, 4'b0000);
    check_upd("basic.scan2", 4);
    scan4({P_A, P_3, P_2, P_1});
    idle(4);
    check_out("basic.recommit", 16'hA321, 4'b1111, 4'b0000, 4'b0000);
    check_upd("basic.recommit", 0);

    // Alternate 7/b patterns, an undecodable pattern and a blank.
    scan4({P_BLANK, P_BAD, P_BALT, P_7ALT});
    idle(4);
    check_out("alt.scan1", 16'hA321, 4'b1111, 4'b0000, 4'b0000);
    scan4({P_BLANK, P_BAD, P_BALT, P_7ALT});
    idle(4);
    check_out("alt.scan2", 16'h00B7, 4'b0011, 4'b1000, 4'b0100);
    check_upd("alt.scan2", 4);

    // Stability filter: alternating 6/5 on digit 0 never commits.
    scan4({P_BLANK, P_BAD, P_BALT, P_6});
    scan4({P_BLANK, P_BAD, P_BALT, P_5});
    scan4({P_BLANK, P_BAD, P_BALT, P_6});
    scan4({P_BLANK, P_BAD, P_BALT, P_5});
    idle(4);
    check_out("stab.alternate", 16'h00B7, 4'b0011, 4'b1000, 4'b0100);
    check_upd("stab.alternate", 0);
    scan4({P_BLANK, P_BAD, P_BALT, P_6});
    idle(4);
    check("stab.first6.hex", 32'(o_hex), 32'h000000B7);
    scan4({P_BLANK, P_BAD, P_BALT, P_6});
    idle(4);
    check_out("stab.second6", 16'h00B6, 4'b0011, 4'b1000, 4'b0100);
    check_upd("stab.second6", 1);

    // Settle boundary: SETTLE-1 cycle slots never capture.
    repeat (2) begin
      drive(4'b1110, P_5, 7);
      idle(12);
    end
    check("settle.short.hex", 32'(o_hex), 32'h000000B6);
    check_upd("settle.short", 0);
    repeat (2) begin
      drive(4'b1110, P_5, 8);
      idle(12);
    end
    check("settle.exact.hex", 32'(o_hex), 32'h000000B5);
    check_upd("settle.exact", 1);

    // Segment glitch at cycle 5 restarts the settle count.
    repeat (2) begin
      drive(4'b1110, P_6, 4);
      drive(4'b1110, P_8, 1);
      drive(4'b1110, P_6, 7);
      idle(12);
    end
    check("glitch.short.hex", 32'(o_hex), 32'h000000B5);
    check_upd("glitch.short", 0);
    repeat (2) begin
      drive(4'b1110, P_6, 4);
      drive(4'b1110, P_8, 1);
      drive(4'b1110, P_6, 8);
      idle(12);
    end
    check("glitch.clean8.hex", 32'(o_hex), 32'h000000B6);
    check_upd("glitch.clean8", 1);

    // Illegal selects leave everything untouched.
    drive(4'b1100, P_5, 50);
    drive(4'b1111, P_5, 50);
    #1;
    check_out("illegal", 16'h00B6, 4'b0011, 4'b1000, 4'b0100);
    check_upd("illegal", 0);

    // Asynchronous reset in the middle of a settle.
    drive(4'b1110, P_1, 4);
    i_rst = 1'b1;
    #1;
    check_out("midreset", 16'h0000, 4'b0000, 4'b0000, 4'b0000);
    check("midreset.upd", 32'(o_upd), 32'h0);
    @(negedge clk);
    i_com = 4'b1111;
    i_seg = P_BLANK;
    i_rst = 1'b0;
    upd_base = upd_cnt;
    idle(20);
    check_out("postreset", 16'h0000, 4'b0000, 4'b0000, 4'b0000);
    check_upd("postreset", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_fnd_scan_decoder
